// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
//   Multicycle control FSM for a shared MIPS-32 datapath with a single
//   shared instruction/data memory port. The IR is decoded once per
//   instruction. Each state then drives the datapath mux selects, load
//   enables and the 4-bit ALU operation. The FSM also counts retired
//   instructions.
//
// Parameters
//   CNT_W      width of the retired-instruction counter
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high; forces every output to 0
//   op         IR[31:26]
//   funct      IR[5:0]
//   zero       ALU zero flag (used for beq/bne)
//   mem_ready  memory completes the current request this cycle
//   mem_req    memory access request
//   mem_we     1 = write (sw), 0 = read
//   iord       memory address: 0 = PC, 1 = ALUOut
//   ir_en      load IR
//   pc_en      load PC
//   pcsrc      0 = ALU result, 1 = ALUOut, 2 = jump address
//   reg_wen    register file write enable
//   regdst     write address: 0 = rt, 1 = rd
//   memtoreg   write data: 0 = ALUOut, 1 = MDR
//   alusrca    A operand: 0 = PC, 1 = rs, 2 = zero-extended shamt
//   alusrcb    B operand: 0 = rt, 1 = 4, 2 = ext imm, 3 = ext imm << 2
//   ext_sign   immediate extender: 1 = sign, 0 = zero
//   alucont    ALU operation code
//   illegal    one-cycle pulse in DECODE for an unsupported op/funct
//   retired    one-cycle pulse when an instruction completes
//   icount     retired-instruction count; wraps to 0
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_en,
  output logic             pc_en,
  output logic [1:0]       pcsrc,
  output logic             reg_wen,
  output logic             regdst,
  output logic             memtoreg,
  output logic [1:0]       alusrca,
  output logic [1:0]       alusrcb,
  output logic             ext_sign,
  output logic [3:0]       alucont,
  output logic             illegal,
  output logic             retired,
  output logic [CNT_W-1:0] icount
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU operation codes
  localparam logic [3:0] ALU_ADDU = 4'd0;
  localparam logic [3:0] ALU_SUBU = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_AND  = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_NOR  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SLT  = 4'd9;
  localparam logic [3:0] ALU_SLL  = 4'd10;
  localparam logic [3:0] ALU_SRL  = 4'd11;
  localparam logic [3:0] ALU_SRA  = 4'd12;
  localparam logic [3:0] ALU_LUI  = 4'd13;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] icount_q;

  // R-type decode (funct field)
  logic       r_legal;
  logic       r_shift;
  logic [3:0] r_alu;

  always_comb begin
    r_legal = 1'b1;
    r_shift = 1'b0;
    r_alu   = ALU_ADDU;
    case (funct)
      6'h20:   r_alu = ALU_ADD;
      6'h21:   r_alu = ALU_ADDU;
      6'h22:   r_alu = ALU_SUB;
      6'h23:   r_alu = ALU_SUBU;
      6'h24:   r_alu = ALU_AND;
      6'h25:   r_alu = ALU_OR;
      6'h26:   r_alu = ALU_XOR;
      6'h27:   r_alu = ALU_NOR;
      6'h2A:   r_alu = ALU_SLT;
      6'h2B:   r_alu = ALU_SLTU;
      6'h00:   begin r_alu = ALU_SLL; r_shift = 1'b1; end
      6'h02:   begin r_alu = ALU_SRL; r_shift = 1'b1; end
      6'h03:   begin r_alu = ALU_SRA; r_shift = 1'b1; end
      default: r_legal = 1'b0;
    endcase
  end

  // I-type ALU decode (opcode field)
  logic       i_legal;
  logic       i_sign;
  logic [3:0] i_alu;

  always_comb begin
    i_legal = 1'b1;
    i_sign  = 1'b1;
    i_alu   = ALU_ADDU;
    case (op)
      OP_ADDI:  i_alu = ALU_ADD;
      OP_ADDIU: i_alu = ALU_ADDU;
      OP_SLTI:  i_alu = ALU_SLT;
      OP_SLTIU: i_alu = ALU_SLTU;
      // Logical immediates and lui take a zero-extended immediate.
      OP_ANDI:  begin i_alu = ALU_AND; i_sign = 1'b0; end
      OP_ORI:   begin i_alu = ALU_OR;  i_sign = 1'b0; end
      OP_XORI:  begin i_alu = ALU_XOR; i_sign = 1'b0; end
      OP_LUI:   begin i_alu = ALU_LUI; i_sign = 1'b0; end
      default:  i_legal = 1'b0;
    endcase
  end

  logic is_mem;
  logic is_branch;
  logic is_rtype;
  logic decode_legal;

  assign is_mem       = (op == OP_LW) || (op == OP_SW);
  assign is_branch    = (op == OP_BEQ) || (op == OP_BNE);
  assign is_rtype     = (op == OP_RTYPE) && r_legal;
  assign decode_legal = is_mem || is_rtype || i_legal || is_branch || (op == OP_J);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (is_mem)              state_d = S_MEMADR;
        else if (is_rtype)       state_d = S_EXEC;
        else if (i_legal)        state_d = S_IEXEC;
        else if (is_branch)      state_d = S_BRANCH;
        else if (op == OP_J)     state_d = S_JUMP;
        else                     state_d = S_FETCH;
      end
      S_MEMADR: state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  if (mem_ready) state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_IEXEC:  state_d = S_IWB;
      S_IWB:    state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_JUMP:   state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output logic. While rst is high, every output stays 0. This holds
  // off any memory request or register write during reset, including
  // an instruction aborted part-way through.
  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_en    = 1'b0;
    pc_en    = 1'b0;
    pcsrc    = 2'd0;
    reg_wen  = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 2'd0;
    alusrcb  = 2'd0;
    ext_sign = 1'b0;
    alucont  = ALU_ADDU;
    illegal  = 1'b0;
    retired  = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          // PC + 4 is computed while the instruction is read. IR and PC
          // load only in the cycle the memory delivers.
          mem_req = 1'b1;
          alusrcb = 2'd1;
          ir_en   = mem_ready;
          pc_en   = mem_ready;
        end
        S_DECODE: begin
          // Branch target speculatively computed into ALUOut
          alusrcb  = 2'd3;
          ext_sign = 1'b1;
          illegal  = !decode_legal;
        end
        S_MEMADR: begin
          alusrca  = 2'd1;
          alusrcb  = 2'd2;
          ext_sign = 1'b1;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
        end
        S_MEMWB: begin
          reg_wen  = 1'b1;
          memtoreg = 1'b1;
          retired  = 1'b1;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = 1'b1;
          retired = mem_ready;
        end
        S_EXEC: begin
          alusrca = r_shift ? 2'd2 : 2'd1;
          alucont = r_alu;
        end
        S_ALUWB: begin
          reg_wen = 1'b1;
          regdst  = 1'b1;
          retired = 1'b1;
        end
        S_IEXEC: begin
          alusrca  = 2'd1;
          alusrcb  = 2'd2;
          ext_sign = i_sign;
          alucont  = i_alu;
        end
        S_IWB: begin
          reg_wen = 1'b1;
          retired = 1'b1;
        end
        S_BRANCH: begin
          alusrca = 2'd1;
          alucont = ALU_SUB;
          pcsrc   = 2'd1;
          pc_en   = (op == OP_BEQ) ? zero : !zero;
          retired = 1'b1;
        end
        S_JUMP: begin
          pcsrc   = 2'd2;
          pc_en   = 1'b1;
          retired = 1'b1;
        end
        default: begin
          mem_req = 1'b0;
        end
      endcase
    end
  end

  // Retired-instruction counter; natural binary wrap from all-ones to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      icount_q <= '0;
    end else if (retired) begin
      icount_q <= icount_q + CNT_ONE;
    end
  end

  assign icount = icount_q;

endmodule
